// File: rtl/ram_if_pkg.sv
// Shared defaults and FSM state encoding for the sync RAM access controller.
package ram_if_pkg;

   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAKE  = 3'd1,
      S_SETUP = 3'd2,
      S_EXEC  = 3'd3,
      S_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/sync_ram_access_ctrl.sv
// Initiator for the single-port sync RAM: sequences the RAM's enable-driven FSM per
// valid/ready request and returns one held response per request.
module sync_ram_access_ctrl
   import ram_if_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              ram_rst,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_e            state_q, state_d;
   logic              chain_q, chain_d;
   logic              lat_we_q, lat_we_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_we_q, rsp_we_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              en_c, we_c;
   logic              load;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         chain_q     <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         chain_q     <= chain_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      chain_d     = chain_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      req_ready   = 1'b0;
      en_c        = 1'b0;
      we_c        = 1'b0;
      ram_addr    = lat_addr_q;
      ram_wdata   = lat_wdata_q;
      load        = !rsp_valid_q || rsp_ready;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               lat_we_d    = req_we;
               lat_addr_d  = req_addr;
               lat_wdata_d = req_wdata;
               state_d     = S_WAKE;
            end
         end
         S_WAKE: begin
            en_c    = 1'b1;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            en_c    = 1'b1;
            we_c    = lat_we_q;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            en_c    = 1'b1;
            we_c    = lat_we_q;
            chain_d = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            if (load) begin
               rsp_valid_d = 1'b1;
               rsp_we_d    = lat_we_q;
               rsp_rdata_d = lat_we_q ? '0 : ram_rdata;
               if (req_valid) begin
                  req_ready   = 1'b1;
                  lat_we_d    = req_we;
                  lat_addr_d  = req_addr;
                  lat_wdata_d = req_wdata;
               end
               // RAM is still ACTIVE after the op, so a chained request skips WAKE
               // and presents its setup directly from the request pins.
               if (chain_q && req_valid) begin
                  en_c      = 1'b1;
                  we_c      = req_we;
                  ram_addr  = req_addr;
                  ram_wdata = req_wdata;
                  state_d   = S_EXEC;
               end else if (req_valid) begin
                  state_d = S_WAKE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               chain_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram_en    = en_c & rst_n;
   assign ram_we    = we_c & en_c & rst_n;
   assign ram_rst   = ~rst_n;
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sync_ram_access_ctrl.sv
// Bench for sync_ram_access_ctrl: behavioural RAM device, in-order response scoreboard
// over a flat memory image, directed timing scenarios and a randomized traffic phase.
module tb_sync_ram_access_ctrl;

   typedef struct packed {
      logic       we;
      logic [3:0] a;
      logic [7:0] d;
   } op_t;

   logic       clk;
   logic       rst_n;
   logic       req_valid, req_ready, req_we;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid, rsp_ready, rsp_we;
   logic [7:0] rsp_rdata;
   logic       busy, ram_rst, ram_en, ram_we;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata = 8'h00;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned cyc = 0;

   sync_ram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
      .busy(busy), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // RAM device: IDLE -en-> ACTIVE -en-> WRITE|READ -en-> op, back to ACTIVE; en=0 -> IDLE.
   logic [7:0] ram_mem [16] = '{default: 8'h00};
   int         rs = 0;
   always @(posedge clk) begin
      if (ram_rst || !ram_en) rs <= 0;
      else case (rs)
         0: rs <= 1;
         1: rs <= ram_we ? 2 : 3;
         2: begin ram_mem[ram_addr] <= ram_wdata; rs <= 1; end
         default: begin ram_rdata <= ram_mem[ram_addr]; rs <= 1; end
      endcase
   end

   // Scoreboard: ops complete in acceptance order; reads see all earlier writes.
   logic [7:0]  ref_mem [16] = '{default: 8'h00};
   op_t         exp_q[$];
   int unsigned hs_cyc[$];
   logic        acc_flag = 1'b0;
   logic        prev_hold = 1'b0;
   logic        prev_we;
   logic [7:0]  prev_rd;

   always @(negedge clk) begin
      op_t op;
      if (!rst_n) begin
         exp_q.delete();
         prev_hold = 1'b0;
         acc_flag  = 1'b0;
      end else begin
         if (ram_we) check("ram_we_without_en", ram_en, 1);
         if (prev_hold) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_we", rsp_we, prev_we);
            check("rsp_hold_rdata", rsp_rdata, prev_rd);
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", exp_q.size(), 1);
            end else begin
               op = exp_q.pop_front();
               check("rsp_we", rsp_we, op.we);
               check("rsp_rdata", rsp_rdata, op.we ? 8'h00 : ref_mem[op.a]);
               if (op.we) ref_mem[op.a] = op.d;
               hs_cyc.push_back(cyc);
            end
         end
         prev_hold = rsp_valid && !rsp_ready;
         prev_we   = rsp_we;
         prev_rd   = rsp_rdata;
         acc_flag  = req_valid && req_ready;
         if (acc_flag) begin
            op.we = req_we; op.a = req_addr; op.d = req_wdata;
            exp_q.push_back(op);
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Presents one request and returns just after the accepting edge with req_valid low.
   task automatic issue(input logic we, input logic [3:0] a, input logic [7:0] d);
      int unsigned n = 0;
      req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 50) begin n++; @(negedge clk); end
      if (n >= 50) check("accept_timeout", n, 0);
      step();
      req_valid = 1'b0;
   endtask

   task automatic stream(input op_t ops[4], output int unsigned acc[4]);
      for (int i = 0; i < 4; i++) begin
         int unsigned n = 0;
         req_valid = 1'b1; req_we = ops[i].we; req_addr = ops[i].a; req_wdata = ops[i].d;
         @(negedge clk);
         while (!req_ready && n < 50) begin n++; @(negedge clk); end
         if (n >= 50) check("stream_timeout", n, 0);
         step();
         acc[i] = cyc;
      end
      req_valid = 1'b0;
   endtask

   initial begin
      op_t         ops[4];
      int unsigned acc[4];
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_rst", ram_rst, 1);
      step(); rst_n = 1'b1;
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_ram_rst", ram_rst, 0);
      step();

      // Write 0xA5 @3: en on T+1..T+3, we on T+2..T+3, response from T+5
      issue(1'b1, 4'd3, 8'hA5);
      @(negedge clk);
      check("wr_wake_en", ram_en, 1); check("wr_wake_we", ram_we, 0);
      check("wr_wake_ready", req_ready, 0); check("wr_wake_busy", busy, 1);
      @(negedge clk);
      check("wr_setup_en", ram_en, 1); check("wr_setup_we", ram_we, 1);
      check("wr_setup_addr", ram_addr, 3); check("wr_setup_data", ram_wdata, 8'hA5);
      @(negedge clk);
      check("wr_exec_en", ram_en, 1); check("wr_exec_we", ram_we, 1);
      @(negedge clk);
      check("wr_lat4_valid", rsp_valid, 0);
      @(negedge clk);
      check("wr_lat5_valid", rsp_valid, 1); check("wr_rsp_we", rsp_we, 1);
      check("wr_rsp_rdata", rsp_rdata, 0);
      step();

      // Read @3 back
      issue(1'b0, 4'd3, 8'h00);
      repeat (2) @(negedge clk);
      check("rd_setup_we", ram_we, 0); check("rd_setup_en", ram_en, 1);
      repeat (2) @(negedge clk);
      check("rd_lat4_valid", rsp_valid, 0);
      @(negedge clk);
      check("rd_lat5_valid", rsp_valid, 1); check("rd_rdata", rsp_rdata, 8'hA5);
      check("rd_rsp_we", rsp_we, 0);
      step();

      // Chained writes then reads, one op per two cycles
      hs_cyc.delete();
      ops[0] = '{we: 1'b1, a: 4'd0, d: 8'h11};
      ops[1] = '{we: 1'b1, a: 4'd1, d: 8'h22};
      ops[2] = '{we: 1'b0, a: 4'd0, d: 8'h00};
      ops[3] = '{we: 1'b0, a: 4'd1, d: 8'h00};
      stream(ops, acc);
      check("chain_gap01", acc[1] - acc[0], 4);
      check("chain_gap12", acc[2] - acc[1], 2);
      check("chain_gap23", acc[3] - acc[2], 2);
      repeat (12) step();
      check("chain_rsp_count", hs_cyc.size(), 4);
      if (hs_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) check("chain_rsp_gap", hs_cyc[i] - hs_cyc[i-1], 2);
      end

      // Response back-pressure stall
      issue(1'b1, 4'd5, 8'h5A);
      repeat (6) @(negedge clk);
      step();
      rsp_ready = 1'b0;
      issue(1'b0, 4'd5, 8'h00);
      repeat (5) @(negedge clk);
      check("stall_first_valid", rsp_valid, 1); check("stall_first_rdata", rsp_rdata, 8'h5A);
      step();
      issue(1'b0, 4'd3, 8'h00);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0; req_wdata = 8'h00;
      @(negedge clk);
      check("stall_wake_ready", req_ready, 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_req_ready", req_ready, 0); check("stall_ram_en", ram_en, 0);
         check("stall_rsp_valid", rsp_valid, 1); check("stall_rsp_rdata", rsp_rdata, 8'h5A);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("unstall_req_ready", req_ready, 1); check("unstall_ram_en", ram_en, 0);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check("restart_wake_en", ram_en, 1); check("restart_wake_we", ram_we, 0);
      check("restart_rsp_rdata", rsp_rdata, 8'hA5);
      repeat (8) @(negedge clk);
      step();

      // Reset during S_EXEC of a write abandons it
      issue(1'b1, 4'd7, 8'h3C);
      repeat (6) @(negedge clk);
      step();
      issue(1'b0, 4'd3, 8'h00);
      repeat (6) @(negedge clk);
      step();
      issue(1'b1, 4'd7, 8'hFF);
      step(); step();
      rst_n = 1'b0;
      @(negedge clk);
      check("rstx_ram_en", ram_en, 0); check("rstx_ram_we", ram_we, 0);
      check("rstx_ram_rst", ram_rst, 1);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rstx_busy", busy, 0); check("rstx_rsp_valid", rsp_valid, 0);
      check("rstx_rsp_we", rsp_we, 0); check("rstx_rsp_rdata", rsp_rdata, 0);
      check("rstx_en_after", ram_en, 0); check("rstx_req_ready", req_ready, 1);
      step();
      issue(1'b0, 4'd7, 8'h00);
      repeat (5) @(negedge clk);
      check("rstx_old_value", rsp_rdata, 8'h3C);
      step();

      // Address wrap boundary
      ops[0] = '{we: 1'b1, a: 4'd15, d: 8'hC3};
      ops[1] = '{we: 1'b1, a: 4'd0,  d: 8'h3D};
      ops[2] = '{we: 1'b0, a: 4'd15, d: 8'h00};
      ops[3] = '{we: 1'b0, a: 4'd0,  d: 8'h00};
      stream(ops, acc);
      repeat (12) step();

      // Randomized traffic with random response back-pressure
      for (int i = 0; i < 600; i++) begin
         step();
         if (!req_valid || acc_flag) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            req_wdata = 8'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (20) step();
      @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
      check("drain_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
